serial_bit_feeder: RTL and testbench

Parallel-to-serial feeder that sits directly upstream of the 1010 sequence detector and drives its `din` input. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. A one-entry holding buffer lets back-to-back words stream with no idle gap. When no word is available, the output sits at a constant idle level, so the downstream detector, which samples every cycle, sees a well-defined stream.

---
 rtl/serial_bit_feeder.sv | 137 +++++++++++++
 tb/tb_serial_bit_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Parallel-to-serial feeder for the 1010 sequence detector. Accepts
//   WIDTH-bit words over a valid/ready handshake and emits them one bit per
//   clock. A one-entry holding buffer lets consecutive words stream without
//   an idle gap. The output sits at IDLE_BIT when there is nothing to shift.
//
// Parameters:
//   WIDTH     - bits per word (>= 2)
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  - level on dout while no data is shifted
//
// Ports:
//   clk        in   clock
//   resetn     in   synchronous active-low reset
//   in_data    in   [WIDTH-1:0] word to serialize
//   in_valid   in   in_data is valid
//   in_ready   out  a word can be accepted this cycle
//   dout       out  serial bit (drives the detector din)
//   dout_valid out  dout carries a data bit
//   dout_last  out  dout is the final bit of its word
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] word, word_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic             ready_r;
  logic             dout_r, dout_valid_r, dout_last_r;
  logic             accept;

  // Selects the bit of a word presented at a given position in the stream.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w,
                                    input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] k;
    k = MSB_FIRST ? (LAST_IDX - i) : i;
    return w[k];
  endfunction

  // The ready flop mirrors ~hold_valid; masking with resetn keeps the block
  // closed while reset is held and opens it on the first cycle after release.
  assign in_ready   = ready_r & resetn;
  assign accept     = in_valid & in_ready;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;

  always_comb begin
    state_nxt      = state;
    word_nxt       = word;
    idx_nxt        = idx;
    hold_data_nxt  = hold_data;
    hold_valid_nxt = hold_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          word_nxt  = in_data;
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == LAST_IDX) begin
          // Hold has priority over a same-cycle accept; when hold is full,
          // in_ready is low so the two never coincide.
          idx_nxt = '0;
          if (hold_valid) begin
            word_nxt       = hold_data;
            hold_valid_nxt = 1'b0;
          end else if (accept) begin
            word_nxt = in_data;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt = idx + 1'b1;
          if (accept) begin
            hold_data_nxt  = in_data;
            hold_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Data registers: contents only matter while qualified by state/hold_valid.
  always_ff @(posedge clk) begin
    word      <= word_nxt;
    hold_data <= hold_data_nxt;
  end

  // Control and output registers: outputs are computed from the next state so
  // they leave the block straight from flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      idx          <= '0;
      hold_valid   <= 1'b0;
      ready_r      <= 1'b1;
      dout_r       <= IDLE_BIT;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      hold_valid   <= hold_valid_nxt;
      ready_r      <= ~hold_valid_nxt;
      dout_r       <= (state_nxt == SHIFT) ? pick_bit(word_nxt, idx_nxt) : IDLE_BIT;
      dout_valid_r <= (state_nxt == SHIFT);
      dout_last_r  <= (state_nxt == SHIFT) && (idx_nxt == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder
//   Directed bench for serial_bit_feeder with WIDTH=4. One instance shifts
//   MSB first, a second one LSB first; both share clock and reset.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] in_data, in_data_l;
  logic       in_valid, in_valid_l;
  logic       in_ready, dout, dout_valid, dout_last;
  logic       in_ready_l, dout_l, dout_valid_l, dout_last_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last)
  );

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .resetn(resetn), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .dout(dout_l), .dout_valid(dout_valid_l), .dout_last(dout_last_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, dout, 1'b0);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_last"}, dout_last, 1'b0);
  endtask

  // Called in the first cycle of a word on the MSB-first instance; returns
  // in the cycle after its last bit.
  task automatic run_word(input string tag, input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_dout"}, dout, w[3-i]);
      chk({tag, "_valid"}, dout_valid, 1'b1);
      chk({tag, "_last"}, dout_last, (i == 3));
      tick();
    end
  endtask

  initial begin
    logic [11:0] stream;
    logic [11:0] rdy_exp;
    logic [3:0]  words [3];
    int          sent;
    logic        acc;

    resetn = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid_l = 1'b0; in_data_l = '0;

    // Reset state
    tick(); tick();
    chk_idle("rst");
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_l_valid", dout_valid_l, 1'b0);
    resetn = 1'b1;
    #1;
    chk("rel_ready", in_ready, 1'b1);
    tick();

    // Single word 1010
    in_valid = 1'b1; in_data = 4'b1010;
    tick();
    in_valid = 1'b0;
    run_word("single", 4'b1010);
    chk_idle("single_end");

    // Back-to-back A, 5, C
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC;
    stream  = 12'b1010_0101_1100;
    rdy_exp = 12'b1000_1000_1111;
    sent = 0; in_valid = 1'b1; in_data = words[0];
    for (int c = 0; c <= 12; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < 3) in_data = words[sent];
        else in_valid = 1'b0;
      end
      if (c < 12) begin
        chk("b2b_dout", dout, stream[11-c]);
        chk("b2b_valid", dout_valid, 1'b1);
        chk("b2b_last", dout_last, (c % 4) == 3);
        chk("b2b_ready", in_ready, rdy_exp[11-c]);
      end else begin
        chk_idle("b2b_end");
        chk("b2b_end_ready", in_ready, 1'b1);
      end
    end

    // Last-cycle bypass: 0011 then 1001 offered only on the last-bit cycle
    in_valid = 1'b1; in_data = 4'b0011;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("byp_a_dout", dout, (i == 2));
      tick();
    end
    chk("byp_a_lastbit", dout, 1'b1);
    chk("byp_a_last", dout_last, 1'b1);
    chk("byp_ready_last", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 4'b1001;
    tick();
    in_valid = 1'b0;
    chk("byp_ready_after", in_ready, 1'b1);
    run_word("byp_b", 4'b1001);
    chk_idle("byp_end");

    // LSB-first instance: 0101 leaves as 1,0,1,0
    in_valid_l = 1'b1; in_data_l = 4'b0101;
    tick();
    in_valid_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_dout", dout_l, (i % 2) == 0);
      chk("lsb_valid", dout_valid_l, 1'b1);
      chk("lsb_last", dout_last_l, (i == 3));
      tick();
    end
    chk("lsb_end_valid", dout_valid_l, 1'b0);
    chk("lsb_end_dout", dout_l, 1'b0);

    // Reset mid-word with F waiting in hold
    in_valid = 1'b1; in_data = 4'hA;
    tick();
    chk("rmw_b0", dout, 1'b1);
    chk("rmw_ready0", in_ready, 1'b1);
    in_data = 4'hF;
    tick();
    in_valid = 1'b0;
    chk("rmw_b1", dout, 1'b0);
    chk("rmw_ready_full", in_ready, 1'b0);
    resetn = 1'b0; in_valid = 1'b1; in_data = 4'h6;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("rmw_in_rst");
      chk("rmw_in_rst_ready", in_ready, 1'b0);
    end
    resetn = 1'b1; in_valid = 1'b0;
    #1;
    chk("rmw_rel_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("rmw_after");
    end
    in_valid = 1'b1; in_data = 4'hC;
    tick();
    in_valid = 1'b0;
    run_word("rmw_next", 4'hC);
    chk_idle("rmw_end");

    // Idle gap of 5 cycles between words
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    run_word("gap_a", 4'h5);
    for (int i = 0; i < 5; i++) begin
      chk_idle("gap");
      if (i == 4) begin
        in_valid = 1'b1; in_data = 4'hE;
      end
      if (i < 4) tick();
    end
    tick();
    in_valid = 1'b0;
    run_word("gap_b", 4'hE);
    chk_idle("gap_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
